dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, dmem word-address width.
REQ-002 Parameter DATA_W, default 32, dmem data width.
REQ-003 Parameter RD_LAT, default 1, legal 1..2, cycles from read issue to valid mem_q.
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 r0_valid / r1_valid  in  1  request pending (r0 = processor, r1 = loader/debug port).
REQ-007 r0_ready / r1_ready  out  1  request accepted this cycle.
REQ-008 r0_addr / r1_addr  in  ADDR_W  word address.
REQ-009 r0_wdata / r1_wdata  in  DATA_W  write data.
REQ-010 r0_wren / r1_wren  in  1  1 = write, 0 = read.
REQ-011 r0_rsp_valid / r1_rsp_valid  out  1  read data valid, one-cycle pulse.
REQ-012 r0_rdata / r1_rdata  out  DATA_W  read data.
REQ-013 mem_address  out  ADDR_W; mem_data  out  DATA_W; mem_wren  out  1; mem_q  in  DATA_W: shared dmem port.

Function
REQ-014 SHALL issue at most one request per cycle; issue = rX_valid && rX_ready.
REQ-015 rX_ready SHALL be combinational: high only for the granted requester, and only while its rX_valid is high.
REQ-016 Grant, fixed-priority mode: r0 wins whenever r0_valid = 1.
REQ-017 On issue, mem_address/mem_data/mem_wren SHALL carry the granted request in the same cycle.
REQ-018 With no issue: mem_wren = 0, mem_address = 0, mem_data = 0.
REQ-019 Writes SHALL produce no response.
REQ-020 A read issued in cycle N SHALL yield rX_rsp_valid = 1 and rX_rdata = mem_q in cycle N+RD_LAT, for the issuing requester only.
REQ-021 Tag pipeline: RD_LAT stages of {valid, id}; back-to-back reads SHALL be supported at one per cycle, with responses returned in issue order.
REQ-022 rX_rdata SHALL be 0 whenever rX_rsp_valid = 0.
REQ-023 No forwarding: a read issued the cycle after a write to the same address returns whatever dmem returns.
REQ-024 Simultaneous r0/r1 valid: exactly one ready is asserted; the loser holds its request and is served in a later cycle.

Reset
REQ-025 On reset: tag pipeline cleared, RR pointer set to PRI0, and all outputs 0 in the same cycle.
REQ-026 Reads in flight when reset asserts SHALL never produce rsp_valid, including after reset deasserts.
REQ-027 No request SHALL be issued in a cycle where reset = 1.

Configuration
REQ-028 Macro DMEM_ARB_RR_EN defined: round-robin arbitration using a 2-state pointer FSM, PRI0 / PRI1.
REQ-029 PRI0: r0 preferred; PRI1: r1 preferred.
REQ-030 On a grant to rX the pointer SHALL move to the other requester's state; with no grant it holds.
REQ-031 Macro undefined: fixed priority per REQ-016, and no pointer register is synthesized.

Structure
REQ-032 Shared package dmem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the requester-id type (1 bit), and the PRI0/PRI1 state encoding.
REQ-033 Sub-module dmem_arb_grant SHALL hold the grant logic and pointer FSM; datapath muxing and the tag pipeline SHALL stay in dmem_arbiter.

Verification
REQ-034 r0 read addr 0x010, mem_q = 0xDEADBEEF at N+1 (RD_LAT = 1) -> r0_rsp_valid pulse at N+1 with rdata 0xDEADBEEF; r1_rsp_valid stays 0.
REQ-035 r0 and r1 both valid for 4 cycles, fixed mode -> r0 granted 4 times, r1_ready = 0 throughout.
REQ-036 Same stimulus with DMEM_ARB_RR_EN -> grant sequence r0, r1, r0, r1.
REQ-037 r1 write 0x0000_1234 to 0x3FF, then r1 read 0x3FF next cycle -> mem_wren = 1 only in the first cycle; read response returns dmem data.
REQ-038 RD_LAT = 2: reads r0@0x001, r1@0x002, r0@0x003 on consecutive cycles -> responses at +2 in order, each to its correct requester.
REQ-039 Read issued, reset asserted the next cycle -> no rsp_valid ever appears; all outputs 0 during reset.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared widths, requester id type and arbitration pointer encoding
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    // Requester id carried down the read tag pipeline: 0 = processor, 1 = loader/debug
    typedef logic [0:0] req_id_t;

    localparam req_id_t ID_R0 = 1'b0;
    localparam req_id_t ID_R1 = 1'b1;

    // Round-robin pointer: which requester is currently preferred
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two requester ports plus shared dmem port of the arbiter
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              r0_valid;
    logic              r0_ready;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_wren;
    logic              r0_rsp_valid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_valid;
    logic              r1_ready;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_wren;
    logic              r1_rsp_valid;
    logic [DATA_W-1:0] r1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    // Requesters and dmem model side
    modport master (
        output r0_valid, r0_addr, r0_wdata, r0_wren,
        input  r0_ready, r0_rsp_valid, r0_rdata,
        output r1_valid, r1_addr, r1_wdata, r1_wren,
        input  r1_ready, r1_rsp_valid, r1_rdata,
        input  mem_address, mem_data, mem_wren,
        output mem_q
    );

    // Arbiter side
    modport slave (
        input  r0_valid, r0_addr, r0_wdata, r0_wren,
        output r0_ready, r0_rsp_valid, r0_rdata,
        input  r1_valid, r1_addr, r1_wdata, r1_wren,
        output r1_ready, r1_rsp_valid, r1_rdata,
        output mem_address, mem_data, mem_wren,
        input  mem_q
    );

endinterface

// File: rtl/dmem_arb_grant.sv
// rtl/dmem_arb_grant.sv - grant logic; round-robin pointer FSM when DMEM_ARB_RR_EN is defined
module dmem_arb_grant
    import dmem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic r0_valid_i,
    input  logic r1_valid_i,
    output logic gnt0_o,
    output logic gnt1_o
);

`ifdef DMEM_ARB_RR_EN
    arb_state_e state_q;

    // Grant the preferred requester if it is asking, otherwise the other one
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (!rst_i) begin
            if (state_q == PRI1) begin
                gnt1_o = r1_valid_i;
                gnt0_o = r0_valid_i && !r1_valid_i;
            end else begin
                gnt0_o = r0_valid_i;
                gnt1_o = r1_valid_i && !r0_valid_i;
            end
        end
    end

    // Pointer moves to the requester that just lost its turn; holds when idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PRI0;
        end else if (gnt0_o) begin
            state_q <= PRI1;
        end else if (gnt1_o) begin
            state_q <= PRI0;
        end
    end
`else
    // Fixed priority needs no state, so the clock is left unconnected internally
    logic unused_clk;
    assign unused_clk = clk_i;

    // Processor always wins; nothing is granted while reset is high
    always_comb begin
        gnt0_o = r0_valid_i && !rst_i;
        gnt1_o = r1_valid_i && !r0_valid_i && !rst_i;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester dmem arbiter with read tag pipeline (option: DMEM_ARB_RR_EN)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
)(
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    logic              gnt0;
    logic              gnt1;
    logic              rd_issue;
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_vld_d;
    logic [RD_LAT-1:0] tag_id_q;
    logic [RD_LAT-1:0] tag_id_d;
    logic              rsp_vld;
    req_id_t           rsp_id;

    dmem_arb_grant u_grant (
        .clk_i      (clock),
        .rst_i      (reset),
        .r0_valid_i (bus.r0_valid),
        .r1_valid_i (bus.r1_valid),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1)
    );

    assign bus.r0_ready = gnt0;
    assign bus.r1_ready = gnt1;

    // Drive the shared dmem port from the granted request, or all zeros when idle
    always_comb begin
        bus.mem_address = '0;
        bus.mem_data    = '0;
        bus.mem_wren    = 1'b0;
        rd_issue        = 1'b0;
        if (gnt0) begin
            bus.mem_address = bus.r0_addr;
            bus.mem_data    = bus.r0_wdata;
            bus.mem_wren    = bus.r0_wren;
            rd_issue        = !bus.r0_wren;
        end else if (gnt1) begin
            bus.mem_address = bus.r1_addr;
            bus.mem_data    = bus.r1_wdata;
            bus.mem_wren    = bus.r1_wren;
            rd_issue        = !bus.r1_wren;
        end
    end

    // Shift read tags one stage per cycle; stage 0 captures the read issued now
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = rd_issue;
        tag_id_d[0]  = gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    // Tag pipeline registers; reset drops every read in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Last stage lines up with mem_q; route it to the requester that issued the read
    always_comb begin
        rsp_vld          = tag_vld_q[RD_LAT-1] && !reset;
        rsp_id           = tag_id_q[RD_LAT-1];
        bus.r0_rsp_valid = rsp_vld && (rsp_id == ID_R0);
        bus.r1_rsp_valid = rsp_vld && (rsp_id == ID_R1);
        bus.r0_rdata     = bus.r0_rsp_valid ? bus.mem_q : '0;
        bus.r1_rdata     = bus.r1_rsp_valid ? bus.mem_q : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven check of dmem_arbiter at RD_LAT 1 and 2
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam int NV  = 27;
    localparam int N1  = 17;

    logic clk;
    logic rst1;
    logic rst2;

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) if1 ();
    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) if2 ();

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1)) dut1 (
        .clock (clk),
        .reset (rst1),
        .bus   (if1)
    );

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(2)) dut2 (
        .clock (clk),
        .reset (rst2),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0, w0, v1, w1;
        logic [11:0] a0, a1;
        logic [31:0] d0, d1, mq;
        logic        rdy0, rdy1, wren, rsp0, rsp1;
        logic [11:0] maddr;
        logic [31:0] mdata, rd0, rd1;
    } vec_t;

    vec_t tbl [NV];
    int total;
    int bad;

    task automatic set_in(input int i, input logic rst,
                          input logic v0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                          input logic v1, input logic w1, input logic [11:0] a1, input logic [31:0] d1,
                          input logic [31:0] mq);
        tbl[i].rst = rst;
        tbl[i].v0 = v0; tbl[i].w0 = w0; tbl[i].a0 = a0; tbl[i].d0 = d0;
        tbl[i].v1 = v1; tbl[i].w1 = w1; tbl[i].a1 = a1; tbl[i].d1 = d1;
        tbl[i].mq = mq;
    endtask

    task automatic set_out(input int i, input logic rdy0, input logic rdy1,
                           input logic [11:0] maddr, input logic [31:0] mdata, input logic wren,
                           input logic rsp0, input logic [31:0] rd0,
                           input logic rsp1, input logic [31:0] rd1);
        tbl[i].rdy0 = rdy0; tbl[i].rdy1 = rdy1;
        tbl[i].maddr = maddr; tbl[i].mdata = mdata; tbl[i].wren = wren;
        tbl[i].rsp0 = rsp0; tbl[i].rd0 = rd0;
        tbl[i].rsp1 = rsp1; tbl[i].rd1 = rd1;
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic idle1();
        if1.r0_valid = 0; if1.r0_wren = 0; if1.r0_addr = '0; if1.r0_wdata = '0;
        if1.r1_valid = 0; if1.r1_wren = 0; if1.r1_addr = '0; if1.r1_wdata = '0;
        if1.mem_q = '0;
    endtask

    task automatic idle2();
        if2.r0_valid = 0; if2.r0_wren = 0; if2.r0_addr = '0; if2.r0_wdata = '0;
        if2.r1_valid = 0; if2.r1_wren = 0; if2.r1_addr = '0; if2.r1_wdata = '0;
        if2.mem_q = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst1  = 1'b1;
        rst2  = 1'b1;
        idle1();
        idle2();

        // RD_LAT = 1 rows (dut1); responses appear one row after issue
        set_in (0, 1, 0,0,12'h000,0,          0,0,12'h000,0,          32'h0);
        set_out(0, 0,0,12'h000,0,0, 0,0, 0,0);
        for (int k = 1; k <= 4; k++)
            set_in(k, 0, 1,0,12'h020,0, 1,0,12'h030,0, 32'hA000_0000 + 32'(k));
        set_out(1, 1,0,12'h020,0,0, 0,0, 0,0);
        set_out(2, !RR,RR, RR ? 12'h030 : 12'h020,0,0, 1,32'hA000_0002, 0,0);
        set_out(3, 1,0,12'h020,0,0, !RR, RR ? 32'h0 : 32'hA000_0003, RR, RR ? 32'hA000_0003 : 32'h0);
        set_out(4, !RR,RR, RR ? 12'h030 : 12'h020,0,0, 1,32'hA000_0004, 0,0);
        set_in (5, 0, 0,0,12'h000,0,          0,0,12'h000,0,          32'hA000_0005);
        set_out(5, 0,0,12'h000,0,0, !RR, RR ? 32'h0 : 32'hA000_0005, RR, RR ? 32'hA000_0005 : 32'h0);
        set_in (6, 0, 1,0,12'h010,0,          0,0,12'h000,0,          32'h5555_5555);
        set_out(6, 1,0,12'h010,0,0, 0,0, 0,0);
        set_in (7, 0, 0,0,12'h000,0,          0,0,12'h000,0,          32'hDEAD_BEEF);
        set_out(7, 0,0,12'h000,0,0, 1,32'hDEAD_BEEF, 0,0);
        set_in (8, 0, 0,0,12'h000,0,          1,1,12'h3FF,32'h1234,   32'hCAFE_0000);
        set_out(8, 0,1,12'h3FF,32'h1234,1, 0,0, 0,0);
        set_in (9, 0, 0,0,12'h000,0,          1,0,12'h3FF,0,          32'h77);
        set_out(9, 0,1,12'h3FF,0,0, 0,0, 0,0);
        set_in (10,0, 0,0,12'h000,0,          0,0,12'h000,0,          32'h1234);
        set_out(10,0,0,12'h000,0,0, 0,0, 1,32'h1234);
        set_in (11,0, 1,1,12'h005,32'hFFFF_0000, 1,0,12'h006,0,       32'h11);
        set_out(11,1,0,12'h005,32'hFFFF_0000,1, 0,0, 0,0);
        set_in (12,0, 0,0,12'h000,0,          1,0,12'h006,0,          32'h22);
        set_out(12,0,1,12'h006,0,0, 0,0, 0,0);
        set_in (13,0, 0,0,12'h000,0,          0,0,12'h000,0,          32'hBBBB_0000);
        set_out(13,0,0,12'h000,0,0, 0,0, 1,32'hBBBB_0000);
        set_in (14,0, 1,0,12'h040,0,          0,0,12'h000,0,          32'h33);
        set_out(14,1,0,12'h040,0,0, 0,0, 0,0);
        set_in (15,1, 1,0,12'h040,0,          0,0,12'h000,0,          32'h99);
        set_out(15,0,0,12'h000,0,0, 0,0, 0,0);
        set_in (16,0, 0,0,12'h000,0,          0,0,12'h000,0,          32'h99);
        set_out(16,0,0,12'h000,0,0, 0,0, 0,0);

        // RD_LAT = 2 rows (dut2); responses appear two rows after issue
        set_in (17,1, 0,0,12'h000,0,          0,0,12'h000,0,          32'h0);
        set_out(17,0,0,12'h000,0,0, 0,0, 0,0);
        set_in (18,0, 1,0,12'h001,0,          0,0,12'h000,0,          32'h0);
        set_out(18,1,0,12'h001,0,0, 0,0, 0,0);
        set_in (19,0, 0,0,12'h000,0,          1,0,12'h002,0,          32'h0);
        set_out(19,0,1,12'h002,0,0, 0,0, 0,0);
        set_in (20,0, 1,0,12'h003,0,          0,0,12'h000,0,          32'h1);
        set_out(20,1,0,12'h003,0,0, 1,32'h1, 0,0);
        set_in (21,0, 0,0,12'h000,0,          0,0,12'h000,0,          32'h2);
        set_out(21,0,0,12'h000,0,0, 0,0, 1,32'h2);
        set_in (22,0, 0,0,12'h000,0,          0,0,12'h000,0,          32'h3);
        set_out(22,0,0,12'h000,0,0, 1,32'h3, 0,0);
        set_in (23,0, 0,0,12'h000,0,          1,0,12'h004,0,          32'h0);
        set_out(23,0,1,12'h004,0,0, 0,0, 0,0);
        set_in (24,1, 0,0,12'h000,0,          1,0,12'h004,0,          32'h5);
        set_out(24,0,0,12'h000,0,0, 0,0, 0,0);
        set_in (25,0, 0,0,12'h000,0,          0,0,12'h000,0,          32'h6);
        set_out(25,0,0,12'h000,0,0, 0,0, 0,0);
        set_in (26,0, 0,0,12'h000,0,          0,0,12'h000,0,          32'h7);
        set_out(26,0,0,12'h000,0,0, 0,0, 0,0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            if (i < N1) begin
                rst1 = tbl[i].rst;
                rst2 = 1'b1;
                idle2();
                if1.r0_valid = tbl[i].v0; if1.r0_wren = tbl[i].w0;
                if1.r0_addr  = tbl[i].a0; if1.r0_wdata = tbl[i].d0;
                if1.r1_valid = tbl[i].v1; if1.r1_wren = tbl[i].w1;
                if1.r1_addr  = tbl[i].a1; if1.r1_wdata = tbl[i].d1;
                if1.mem_q    = tbl[i].mq;
            end else begin
                rst1 = 1'b0;
                rst2 = tbl[i].rst;
                idle1();
                if2.r0_valid = tbl[i].v0; if2.r0_wren = tbl[i].w0;
                if2.r0_addr  = tbl[i].a0; if2.r0_wdata = tbl[i].d0;
                if2.r1_valid = tbl[i].v1; if2.r1_wren = tbl[i].w1;
                if2.r1_addr  = tbl[i].a1; if2.r1_wdata = tbl[i].d1;
                if2.mem_q    = tbl[i].mq;
            end
            #3;
            if (i < N1) begin
                chk("r0_ready",     i, 32'(if1.r0_ready),     32'(tbl[i].rdy0));
                chk("r1_ready",     i, 32'(if1.r1_ready),     32'(tbl[i].rdy1));
                chk("mem_address",  i, 32'(if1.mem_address),  32'(tbl[i].maddr));
                chk("mem_data",     i, if1.mem_data,          tbl[i].mdata);
                chk("mem_wren",     i, 32'(if1.mem_wren),     32'(tbl[i].wren));
                chk("r0_rsp_valid", i, 32'(if1.r0_rsp_valid), 32'(tbl[i].rsp0));
                chk("r0_rdata",     i, if1.r0_rdata,          tbl[i].rd0);
                chk("r1_rsp_valid", i, 32'(if1.r1_rsp_valid), 32'(tbl[i].rsp1));
                chk("r1_rdata",     i, if1.r1_rdata,          tbl[i].rd1);
            end else begin
                chk("lat2_r0_ready",     i, 32'(if2.r0_ready),     32'(tbl[i].rdy0));
                chk("lat2_r1_ready",     i, 32'(if2.r1_ready),     32'(tbl[i].rdy1));
                chk("lat2_mem_address",  i, 32'(if2.mem_address),  32'(tbl[i].maddr));
                chk("lat2_mem_data",     i, if2.mem_data,          tbl[i].mdata);
                chk("lat2_mem_wren",     i, 32'(if2.mem_wren),     32'(tbl[i].wren));
                chk("lat2_r0_rsp_valid", i, 32'(if2.r0_rsp_valid), 32'(tbl[i].rsp0));
                chk("lat2_r0_rdata",     i, if2.r0_rdata,          tbl[i].rd0);
                chk("lat2_r1_rsp_valid", i, 32'(if2.r1_rsp_valid), 32'(tbl[i].rsp1));
                chk("lat2_r1_rdata",     i, if2.r1_rdata,          tbl[i].rd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
